// File: rtl/pulse_cmd_queue.sv
// pulse_cmd_queue: small FIFO of pulse-length commands that issues them one
// at a time to the downstream ms pulse generator. The generator's pulse output
// is used as a busy flag, and an optional idle gap separates consecutive pulses.

`ifndef MASTER_CLK_CYC_PER_MS
`define MASTER_CLK_CYC_PER_MS 1000
`endif

module pulse_cmd_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned GAP_MS      = 1,
    parameter int unsigned CYC_PER_MS  = `MASTER_CLK_CYC_PER_MS,
    parameter int unsigned TRIG_CYCLES = 2
) (
    input  logic                       masterClk,
    input  logic                       reset,
    input  logic [7:0]                 cmdLength,
    input  logic                       cmdValid,
    output logic                       cmdReady,
    input  logic                       pulseBusy,
    output logic [7:0]                 pulseLength,
    output logic                       trigger,
    output logic [$clog2(DEPTH+1)-1:0] queueLevel,
    output logic                       overflow,
    input  logic                       clearOverflow
);

    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned LVL_W     = $clog2(DEPTH + 1);
    localparam int unsigned GAP_CYC   = GAP_MS * CYC_PER_MS;
    localparam int unsigned GAP_W     = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam int unsigned CNT_MAX   = (TRIG_CYCLES > 4) ? TRIG_CYCLES : 4;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX);
    // Number of cycles the generator gets to raise its busy flag after trigger drops.
    localparam int unsigned START_WAIT = 4;

    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(START_WAIT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_END,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               trig_q, trig_d;
    logic [7:0]         len_q, len_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic               ovf_q, ovf_d;
    logic [7:0]         mem_q [DEPTH];

    logic accept;
    logic push;
    logic pop;
    logic trig_done;
    logic wait_done;
    logic gap_done;

    assign cmdReady = !reset && (level_q < LVL_FULL);
    assign accept   = cmdValid && cmdReady;
    // Zero-length commands are swallowed: the generator would ignore them anyway.
    assign push     = accept && (cmdLength != 8'd0);
    assign pop      = (state_q == S_IDLE) && (level_q != '0) && !pulseBusy;

    assign trig_done = (cnt_q == TRIG_LAST);
    assign wait_done = (cnt_q == WAIT_LAST);
    assign gap_done  = (GAP_CYC == 0) || (gap_q == GAP_LAST);

    assign trigger     = trig_q;
    assign pulseLength = len_q;
    assign queueLevel  = level_q;
    assign overflow    = ovf_q;

    // State register and all datapath registers, synchronous reset.
    always_ff @(posedge masterClk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            trig_q  <= 1'b0;
            len_q   <= '0;
            level_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            trig_q  <= trig_d;
            len_q   <= len_d;
            level_q <= level_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO storage write at the tail on every queued command.
    always_ff @(posedge masterClk) begin
        if (push) begin
            mem_q[wr_q] <= cmdLength;
        end
    end

    // Next-state logic for the issue sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:       if (pop) state_d = S_ISSUE;
            S_ISSUE:      if (trig_done) state_d = S_WAIT_START;
            S_WAIT_START: begin
                if (pulseBusy) begin
                    state_d = S_WAIT_END;
                end else if (wait_done) begin
                    state_d = S_GAP;
                end
            end
            S_WAIT_END:   if (!pulseBusy) state_d = S_GAP;
            S_GAP:        if (gap_done) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Sequencer outputs: trigger, presented length and the phase counters.
    always_comb begin
        trig_d = trig_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        gap_d  = gap_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    trig_d = 1'b1;
                    len_d  = mem_q[rd_q];
                    cnt_d  = '0;
                end
            end
            S_ISSUE: begin
                if (trig_done) begin
                    trig_d = 1'b0;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_START: begin
                cnt_d = cnt_q + CNT_W'(1);
                gap_d = '0;
            end
            S_WAIT_END: begin
                gap_d = '0;
            end
            S_GAP: begin
                gap_d = gap_q + GAP_W'(1);
            end
            default: begin
                trig_d = 1'b0;
            end
        endcase
    end

    // Queue bookkeeping and sticky overflow; a blocked offer beats a clear.
    always_comb begin
        level_d = level_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ovf_d   = ovf_q;
        if (push) begin
            wr_d = wr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (cmdValid && !cmdReady) begin
            ovf_d = 1'b1;
        end else if (clearOverflow) begin
            ovf_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_cmd_queue.sv
// tb_pulse_cmd_queue: directed scenarios followed by a randomized run checked
// against a transaction-level queue model with a stub pulse generator.

module tb_pulse_cmd_queue;

    localparam int DEPTH = 4;
    localparam int G     = 8;   // GAP_MS * CYC_PER_MS
    localparam int TRIG  = 2;

    logic       masterClk;
    logic       reset;
    logic [7:0] cmdLength;
    logic       cmdValid;
    logic       cmdReady;
    logic       pulseBusy;
    logic [7:0] pulseLength;
    logic       trigger;
    logic [2:0] queueLevel;
    logic       overflow;
    logic       clearOverflow;

    logic man_busy;
    logic gen_en;
    logic gen_busy;
    logic gen_prev;
    int   gen_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // model state for the randomized phase
    int   q[$];
    logic ovf_m;
    logic trig_prev;
    logic busy_last;
    int   since_fall;
    int   hi_cnt;
    int   last_len;

    pulse_cmd_queue #(
        .DEPTH       (DEPTH),
        .GAP_MS      (1),
        .CYC_PER_MS  (8),
        .TRIG_CYCLES (TRIG)
    ) dut (
        .masterClk     (masterClk),
        .reset         (reset),
        .cmdLength     (cmdLength),
        .cmdValid      (cmdValid),
        .cmdReady      (cmdReady),
        .pulseBusy     (pulseBusy),
        .pulseLength   (pulseLength),
        .trigger       (trigger),
        .queueLevel    (queueLevel),
        .overflow      (overflow),
        .clearOverflow (clearOverflow)
    );

    initial masterClk = 1'b0;
    always #5 masterClk = ~masterClk;

    assign pulseBusy = gen_en ? gen_busy : man_busy;

    // Stub generator: answers a fresh trigger with a short busy pulse, sometimes not at all.
    always @(posedge masterClk) begin
        gen_prev <= trigger;
        if (!gen_en) begin
            gen_busy <= 1'b0;
            gen_cnt  <= 0;
        end else if (trigger && !gen_prev) begin
            if ($urandom_range(5, 0) != 0) begin
                gen_busy <= 1'b1;
                gen_cnt  <= int'($urandom_range(12, 2));
            end
        end else if (gen_cnt > 0) begin
            gen_cnt <= gen_cnt - 1;
            if (gen_cnt == 1) gen_busy <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge masterClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Release busy, wait for the next issue, check it, then play a 3-cycle pulse.
    task automatic pulse_cycle(input int exp_len, input int exp_lvl, output int n);
        logic found;
        found = 1'b0;
        n = 0;
        man_busy = 1'b0;
        for (int i = 1; i <= 60 && !found; i++) begin
            tick();
            if (trigger) begin
                found = 1'b1;
                n = i;
            end
        end
        chk("pc_found", 32'(found), 1);
        chk("pc_len", 32'(pulseLength), exp_len);
        chk("pc_level", 32'(queueLevel), exp_lvl);
        tick();
        chk("pc_trig_hold", 32'(trigger), 1);
        tick();
        chk("pc_trig_drop", 32'(trigger), 0);
        man_busy = 1'b1;
        repeat (3) tick();
    endtask

    // One cycle of the randomized phase, checked against the queue model.
    task automatic rcycle(input logic v, input logic [7:0] len, input logic clr);
        logic exp_ready;
        logic busy_pre;
        int   exp_len;
        cmdValid      = v;
        cmdLength     = len;
        clearOverflow = clr;
        exp_ready = (q.size() < DEPTH);
        chk("r_ready", 32'(cmdReady), 32'(exp_ready));
        busy_pre = pulseBusy;
        tick();
        if (!busy_pre && busy_last) since_fall = 0;
        else if (since_fall < 100000) since_fall++;
        busy_last = busy_pre;
        if (trigger && !trig_prev) begin
            chk("r_issue_has_cmd", 32'(q.size() > 0), 1);
            exp_len = (q.size() > 0) ? q.pop_front() : 0;
            chk("r_issue_len", 32'(pulseLength), exp_len);
            chk("r_issue_not_busy", 32'(busy_pre), 0);
            chk("r_issue_spacing", 32'(since_fall >= G + 1), 1);
            last_len = exp_len;
            hi_cnt = 0;
        end
        if (v && exp_ready && len != 8'd0) q.push_back(int'(len));
        if (v && !exp_ready) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        chk("r_level", 32'(queueLevel), q.size());
        chk("r_overflow", 32'(overflow), 32'(ovf_m));
        if (trigger) begin
            hi_cnt++;
            chk("r_len_stable", 32'(pulseLength), last_len);
        end else if (trig_prev) begin
            chk("r_trig_width", hi_cnt, TRIG);
        end
        trig_prev = trigger;
    endtask

    initial begin
        int   n;
        logic any;
        logic found;
        int   lens[3];

        reset = 1'b1; cmdValid = 1'b0; cmdLength = '0; clearOverflow = 1'b0;
        man_busy = 1'b0; gen_en = 1'b0;
        tick(); tick();
        chk("rst_ready", 32'(cmdReady), 0);
        chk("rst_trig", 32'(trigger), 0);
        chk("rst_len", 32'(pulseLength), 0);
        chk("rst_level", 32'(queueLevel), 0);
        chk("rst_ovf", 32'(overflow), 0);
        reset = 1'b0;
        tick();
        chk("ready_after_rst", 32'(cmdReady), 1);

        // single command: minimum latency, trigger width, gap before the next one
        cmdLength = 8'd5; cmdValid = 1'b1;
        tick();
        cmdValid = 1'b0;
        chk("t1_level_e0", 32'(queueLevel), 1);
        chk("t1_trig_e0", 32'(trigger), 0);
        tick();
        chk("t1_trig_e1", 32'(trigger), 1);
        chk("t1_len_e1", 32'(pulseLength), 5);
        chk("t1_level_e1", 32'(queueLevel), 0);
        tick();
        chk("t1_trig_e2", 32'(trigger), 1);
        tick();
        chk("t1_trig_e3", 32'(trigger), 0);
        chk("t1_len_hold", 32'(pulseLength), 5);
        man_busy = 1'b1;
        cmdLength = 8'd9; cmdValid = 1'b1;
        tick();
        cmdValid = 1'b0;
        chk("t1_level_q9", 32'(queueLevel), 1);
        any = 1'b0;
        repeat (5) begin tick(); any = any | trigger; end
        chk("t1_no_trig_busy", 32'(any), 0);
        pulse_cycle(9, 0, n);
        chk("t1_gap_cycles", n - 1, G + 1);

        // lost trigger: generator never answers, next command follows after 4 + gap
        man_busy = 1'b0;
        repeat (12) tick();
        cmdLength = 8'd4; cmdValid = 1'b1;
        tick();
        cmdValid = 1'b0;
        tick();
        chk("t5_trig", 32'(trigger), 1);
        chk("t5_len", 32'(pulseLength), 4);
        cmdLength = 8'd8; cmdValid = 1'b1;
        tick();
        cmdValid = 1'b0;
        chk("t5_level", 32'(queueLevel), 1);
        tick();
        chk("t5_trig_drop", 32'(trigger), 0);
        found = 1'b0; n = 0;
        for (int i = 1; i <= 60 && !found; i++) begin
            tick();
            if (trigger) begin found = 1'b1; n = i; end
        end
        chk("t5_found", 32'(found), 1);
        chk("t5_lost_cycles", n, 4 + G + 1);
        chk("t5_len2", 32'(pulseLength), 8);
        man_busy = 1'b1;
        repeat (4) tick();
        man_busy = 1'b0;
        repeat (15) tick();

        // burst while busy: strict order, level decrements per issue
        man_busy = 1'b1;
        lens = '{3, 7, 2};
        for (int k = 0; k < 3; k++) begin
            cmdLength = 8'(lens[k]); cmdValid = 1'b1;
            tick();
        end
        cmdValid = 1'b0;
        chk("t2_level3", 32'(queueLevel), 3);
        repeat (3) tick();
        chk("t2_no_trig", 32'(trigger), 0);
        for (int k = 0; k < 3; k++) begin
            pulse_cycle(lens[k], 2 - k, n);
            chk("t2_spacing", n - 1, (k == 0) ? 0 : G + 1);
        end
        man_busy = 1'b0;
        repeat (12) tick();

        // full / overflow
        man_busy = 1'b1;
        cmdLength = 8'd1; cmdValid = 1'b1;
        repeat (4) tick();
        chk("t3_level_full", 32'(queueLevel), 4);
        chk("t3_ready_full", 32'(cmdReady), 0);
        chk("t3_ovf_before", 32'(overflow), 0);
        tick();
        chk("t3_ovf_set", 32'(overflow), 1);
        chk("t3_level_sat", 32'(queueLevel), 4);
        clearOverflow = 1'b1;
        tick();
        chk("t3_set_wins", 32'(overflow), 1);
        cmdValid = 1'b0;
        tick();
        chk("t3_cleared", 32'(overflow), 0);
        clearOverflow = 1'b0;
        man_busy = 1'b0; cmdValid = 1'b1;
        chk("t3_ready_before_pop", 32'(cmdReady), 0);
        tick();
        cmdValid = 1'b0;
        chk("t3_pop_trig", 32'(trigger), 1);
        chk("t3_pop_level", 32'(queueLevel), 3);
        chk("t3_pop_ovf", 32'(overflow), 1);
        clearOverflow = 1'b1;
        tick();
        clearOverflow = 1'b0;
        chk("t3_ovf_clr2", 32'(overflow), 0);
        tick();
        man_busy = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            pulse_cycle(1, 2 - k, n);
            chk("t3_spacing", n - 1, G + 1);
        end
        man_busy = 1'b0;
        repeat (12) tick();

        // zero length accepted and dropped
        chk("t4_ready", 32'(cmdReady), 1);
        cmdLength = 8'd0; cmdValid = 1'b1;
        tick();
        cmdValid = 1'b0;
        chk("t4_level", 32'(queueLevel), 0);
        any = 1'b0;
        repeat (5) begin tick(); any = any | trigger; end
        chk("t4_no_trig", 32'(any), 0);

        // reset mid-pulse
        man_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cmdLength = 8'(10 + k); cmdValid = 1'b1;
            tick();
        end
        cmdValid = 1'b0;
        chk("t6_level_pre", 32'(queueLevel), 4);
        chk("t6_ovf_pre", 32'(overflow), 1);
        reset = 1'b1;
        tick();
        chk("t6_level", 32'(queueLevel), 0);
        chk("t6_trig", 32'(trigger), 0);
        chk("t6_ovf", 32'(overflow), 0);
        chk("t6_ready_in_rst", 32'(cmdReady), 0);
        reset = 1'b0;
        cmdLength = 8'd6; cmdValid = 1'b1;
        tick();
        cmdValid = 1'b0;
        chk("t6_level_new", 32'(queueLevel), 1);
        any = 1'b0;
        repeat (4) begin tick(); any = any | trigger; end
        chk("t6_hold_while_busy", 32'(any), 0);
        man_busy = 1'b0;
        tick();
        chk("t6_issue", 32'(trigger), 1);
        chk("t6_issue_len", 32'(pulseLength), 6);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_trig_drop", 32'(trigger), 0);
        chk("t6_len_rst", 32'(pulseLength), 0);

        // randomized traffic against the queue model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        gen_en = 1'b1;
        tick();
        q.delete();
        ovf_m = 1'b0; trig_prev = trigger; busy_last = pulseBusy;
        since_fall = 1000; hi_cnt = 0; last_len = 0;
        for (int c = 0; c < 1500; c++) begin
            rcycle(($urandom_range(99, 0) < 35), 8'($urandom_range(6, 0)),
                   ($urandom_range(19, 0) == 0));
        end
        for (int c = 0; c < 3000 && (q.size() > 0 || trigger); c++) begin
            rcycle(1'b0, 8'd0, 1'b0);
        end
        chk("r_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
